// File: rtl/rob_alloc_if.sv
// Decode/writeback/commit handshake bundle for the ROB allocator.
// master drives requests and writebacks; slave (rob_alloc) returns the grant, the commit and the occupancy.
interface rob_alloc_if #(
    parameter int ROB_DEPTH = 16
);
    localparam int ROB = $clog2(ROB_DEPTH);

    logic           flush_;
    logic           alloc_req_;
    logic           alloc_e_;
    logic [ROB-1:0] alloc_rob_id;
    logic           wb_e_;
    logic [ROB-1:0] wb_rob_id;
    logic           commit_e_;
    logic [ROB-1:0] com_rob_id;
    logic           full;
    logic           empty;
    logic [ROB:0]   count;

    modport master (
        output flush_, alloc_req_, wb_e_, wb_rob_id,
        input  alloc_e_, alloc_rob_id, commit_e_, com_rob_id, full, empty, count
    );

    modport slave (
        input  flush_, alloc_req_, wb_e_, wb_rob_id,
        output alloc_e_, alloc_rob_id, commit_e_, com_rob_id, full, empty, count
    );
endinterface

// File: rtl/rob_alloc.sv
// ROB id allocator with in-order commit; define ROB_WB_BYPASS_EN to let a head writeback commit in its own cycle.
// Latency: grant and commit are combinational from registered state; writeback-to-commit 1 cycle (0 with bypass).
// Backpressure: alloc_e_ stays high while full or flushing; decode holds alloc_req_ until granted.
module rob_alloc #(
    parameter int ROB_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    rob_alloc_if.slave rob
);
    localparam int           ROB   = $clog2(ROB_DEPTH);
    localparam logic [ROB:0] DEPTH = (ROB+1)'(ROB_DEPTH);

    logic [ROB-1:0]       head;
    logic [ROB-1:0]       tail;
    logic [ROB:0]         count;
    logic [ROB_DEPTH-1:0] done;
    logic [ROB_DEPTH-1:0] done_nxt;
    logic [ROB-1:0]       wb_off;
    logic                 full;
    logic                 empty;
    logic                 grant;
    logic                 commit;
    logic                 wb_vld;
    logic                 wb_hit;

    assign full   = (count == DEPTH);
    assign empty  = (count == '0);
    assign grant  = !rob.alloc_req_ && !full && rob.flush_;

    // A slot is occupied when its distance from head, modulo the wrap, is below count.
    assign wb_off = rob.wb_rob_id - head;
    assign wb_vld = !rob.wb_e_ && rob.flush_ && ({1'b0, wb_off} < count);

`ifdef ROB_WB_BYPASS_EN
    assign wb_hit = wb_vld && (rob.wb_rob_id == head);
`else
    assign wb_hit = 1'b0;
`endif

    assign commit = !empty && rob.flush_ && (done[head] || wb_hit);

    // Commit clears last so a bypassed head writeback never leaves its done bit behind.
    always_comb begin
        done_nxt = done;
        if (grant)  done_nxt[tail]          = 1'b0;
        if (wb_vld) done_nxt[rob.wb_rob_id] = 1'b1;
        if (commit) done_nxt[head]          = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset || !rob.flush_) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            done <= done_nxt;
            if (grant)  tail <= tail + ROB'(1);
            if (commit) head <= head + ROB'(1);
            case ({grant, commit})
                2'b10:   count <= count + (ROB+1)'(1);
                2'b01:   count <= count - (ROB+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rob.alloc_e_     = !grant;
    assign rob.alloc_rob_id = tail;
    assign rob.commit_e_    = !commit;
    assign rob.com_rob_id   = head;
    assign rob.full         = full;
    assign rob.empty        = empty;
    assign rob.count        = count;
endmodule

// File: tb/tb_rob_alloc.sv
// Scenario bench for rob_alloc: allocated ids are queued as the expected commit order and popped on each commit.
module tb_rob_alloc;
    localparam int DEPTH = 16;
`ifdef ROB_WB_BYPASS_EN
    localparam int NB = 0;
`else
    localparam int NB = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rob_alloc_if #(.ROB_DEPTH(DEPTH)) rif();
    rob_alloc #(.ROB_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .rob(rif));

    int n_checks = 0;
    int n_fail   = 0;
    int exp_com_q[$];
    logic [DEPTH-1:0] occ;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rif.flush_     = 1'b1;
        rif.alloc_req_ = 1'b1;
        rif.wb_e_      = 1'b1;
        rif.wb_rob_id  = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_com_q.delete();
        occ = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        #3;
        n_checks++; if (rif.alloc_e_ !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_e got %b want 1", rif.alloc_e_); end
        n_checks++; if (rif.commit_e_ !== 1'b1) begin n_fail++; $display("FAIL reset_commit_e got %b want 1", rif.commit_e_); end
        n_checks++; if (rif.alloc_rob_id !== 4'd0) begin n_fail++; $display("FAIL reset_alloc_id got %0d want 0", rif.alloc_rob_id); end
        n_checks++; if (rif.com_rob_id !== 4'd0) begin n_fail++; $display("FAIL reset_com_id got %0d want 0", rif.com_rob_id); end
        n_checks++; if (rif.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", rif.full); end
        n_checks++; if (rif.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", rif.empty); end
        n_checks++; if (rif.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", rif.count); end
        tick();
        // Reset in the middle of traffic: first id afterwards must be 0.
        for (int i = 0; i < 3; i++) begin
            rif.alloc_req_ = 1'b0;
            tick();
        end
        apply_reset();
        rif.alloc_req_ = 1'b0;
        #3;
        n_checks++; if (rif.alloc_e_ !== 1'b0 || rif.alloc_rob_id !== 4'd0) begin n_fail++; $display("FAIL midreset_alloc got e=%b id=%0d want e=0 id=0", rif.alloc_e_, rif.alloc_rob_id); end
        tick();
        rif.alloc_req_ = 1'b1;
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            rif.alloc_req_ = 1'b0;
            #3;
            n_checks++; if (rif.alloc_e_ !== 1'b0 || rif.alloc_rob_id !== 4'(i)) begin n_fail++; $display("FAIL fill_grant got e=%b id=%0d want e=0 id=%0d", rif.alloc_e_, rif.alloc_rob_id, i); end
            exp_com_q.push_back(i);
            tick();
        end
        #3;
        n_checks++; if (rif.count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d want 16", rif.count); end
        n_checks++; if (rif.full !== 1'b1 || rif.empty !== 1'b0) begin n_fail++; $display("FAIL fill_flags got full=%b empty=%b want 1 0", rif.full, rif.empty); end
        n_checks++; if (rif.alloc_e_ !== 1'b1) begin n_fail++; $display("FAIL fill_17th_reject got %b want 1", rif.alloc_e_); end
        tick();
    endtask

    task automatic test_full_wrap();
        logic exp_c;
        logic exp_a;
        for (int c = 0; c <= NB + 1; c++) begin
            rif.alloc_req_ = 1'b0;
            rif.wb_e_      = (c == 0) ? 1'b0 : 1'b1;
            rif.wb_rob_id  = 4'd0;
            #3;
            exp_c = (c == NB) ? 1'b0 : 1'b1;
            exp_a = (c == NB + 1) ? 1'b0 : 1'b1;
            n_checks++; if (rif.commit_e_ !== exp_c) begin n_fail++; $display("FAIL wrap_commit c%0d got %b want %b", c, rif.commit_e_, exp_c); end
            if (!rif.commit_e_) begin
                n_checks++;
                if (exp_com_q.size() == 0 || rif.com_rob_id !== 4'(exp_com_q[0])) begin n_fail++; $display("FAIL wrap_com_id got %0d queued=%0d", rif.com_rob_id, exp_com_q.size()); end
                if (exp_com_q.size() != 0) void'(exp_com_q.pop_front());
            end
            n_checks++; if (rif.alloc_e_ !== exp_a) begin n_fail++; $display("FAIL wrap_alloc_e c%0d got %b want %b", c, rif.alloc_e_, exp_a); end
            if (!rif.alloc_e_) begin
                n_checks++; if (rif.alloc_rob_id !== 4'd0) begin n_fail++; $display("FAIL wrap_alloc_id got %0d want 0", rif.alloc_rob_id); end
                exp_com_q.push_back(0);
            end
            tick();
        end
        idle_inputs();
        #3;
        n_checks++; if (rif.full !== 1'b1 || rif.com_rob_id !== 4'd1) begin n_fail++; $display("FAIL wrap_after got full=%b head=%0d want 1 1", rif.full, rif.com_rob_id); end
        tick();
    endtask

    task automatic test_out_of_order();
        int         wb_tab[8] = '{2, 0, -1, -1, 1, -1, -1, -1};
        logic [7:0] ooo_exp;
        ooo_exp = 8'b0110_0100 >> (1 - NB);
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rif.alloc_req_ = 1'b0;
            #3;
            n_checks++; if (rif.alloc_e_ !== 1'b0 || rif.alloc_rob_id !== 4'(i)) begin n_fail++; $display("FAIL ooo_grant got e=%b id=%0d want id=%0d", rif.alloc_e_, rif.alloc_rob_id, i); end
            exp_com_q.push_back(i);
            tick();
        end
        rif.alloc_req_ = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rif.wb_e_     = (wb_tab[c] < 0) ? 1'b1 : 1'b0;
            rif.wb_rob_id = (wb_tab[c] < 0) ? 4'd0 : 4'(wb_tab[c]);
            #3;
            n_checks++; if (rif.commit_e_ !== !ooo_exp[c]) begin n_fail++; $display("FAIL ooo_commit c%0d got %b want %b", c, rif.commit_e_, !ooo_exp[c]); end
            if (!rif.commit_e_) begin
                n_checks++;
                if (exp_com_q.size() == 0 || rif.com_rob_id !== 4'(exp_com_q[0])) begin n_fail++; $display("FAIL ooo_com_id got %0d queued=%0d", rif.com_rob_id, exp_com_q.size()); end
                if (exp_com_q.size() != 0) void'(exp_com_q.pop_front());
            end
            tick();
        end
        idle_inputs();
        #3;
        n_checks++; if (rif.count !== 5'd1 || rif.com_rob_id !== 4'd3 || rif.commit_e_ !== 1'b1) begin n_fail++; $display("FAIL ooo_hold3 got count=%0d head=%0d commit_e=%b want 1 3 1", rif.count, rif.com_rob_id, rif.commit_e_); end
        tick();
    endtask

    task automatic test_flush();
        logic exp_c;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            rif.alloc_req_ = 1'b0;
            #3;
            n_checks++; if (rif.alloc_rob_id !== 4'(i)) begin n_fail++; $display("FAIL flush_grant got %0d want %0d", rif.alloc_rob_id, i); end
            exp_com_q.push_back(i);
            tick();
        end
        rif.alloc_req_ = 1'b1;
        rif.wb_e_ = 1'b0; rif.wb_rob_id = 4'd1;
        #3;
        n_checks++; if (rif.commit_e_ !== 1'b1) begin n_fail++; $display("FAIL flush_wb1_commit got %b want 1", rif.commit_e_); end
        tick();
        rif.wb_rob_id = 4'd0;
        #3;
        exp_c = (NB == 0) ? 1'b0 : 1'b1;
        n_checks++; if (rif.commit_e_ !== exp_c) begin n_fail++; $display("FAIL flush_wb0_commit got %b want %b", rif.commit_e_, exp_c); end
        tick();
        rif.flush_ = 1'b0; rif.alloc_req_ = 1'b0; rif.wb_rob_id = 4'd2;
        #3;
        n_checks++; if (rif.commit_e_ !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_commit got %b want 1", rif.commit_e_); end
        n_checks++; if (rif.alloc_e_ !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_alloc got %b want 1", rif.alloc_e_); end
        tick();
        idle_inputs();
        exp_com_q.delete();
        #3;
        n_checks++; if (rif.count !== 5'd0 || rif.empty !== 1'b1) begin n_fail++; $display("FAIL flush_after got count=%0d empty=%b want 0 1", rif.count, rif.empty); end
        n_checks++; if (rif.alloc_rob_id !== 4'd0 || rif.com_rob_id !== 4'd0) begin n_fail++; $display("FAIL flush_ptrs got tail=%0d head=%0d want 0 0", rif.alloc_rob_id, rif.com_rob_id); end
        tick();
        rif.alloc_req_ = 1'b0;
        #3;
        n_checks++; if (rif.alloc_e_ !== 1'b0 || rif.alloc_rob_id !== 4'd0) begin n_fail++; $display("FAIL flush_first_id got e=%b id=%0d want 0 0", rif.alloc_e_, rif.alloc_rob_id); end
        tick();
        rif.alloc_req_ = 1'b1;
        #3;
        n_checks++; if (rif.commit_e_ !== 1'b1 || rif.count !== 5'd1) begin n_fail++; $display("FAIL flush_no_stale got commit_e=%b count=%0d want 1 1", rif.commit_e_, rif.count); end
        tick();
    endtask

    task automatic test_streaming();
        int   m_tail = 4;
        int   wb_ptr = 0;
        int   exp_cnt;
        logic exp_c;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rif.alloc_req_ = 1'b0;
            #3;
            exp_com_q.push_back(i);
            occ[i] = 1'b1;
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            rif.alloc_req_ = 1'b0;
            rif.wb_e_      = 1'b0;
            rif.wb_rob_id  = 4'(wb_ptr);
            #3;
            n_checks++; if (rif.alloc_e_ !== 1'b0 || rif.alloc_rob_id !== 4'(m_tail)) begin n_fail++; $display("FAIL stream_grant i%0d got e=%b id=%0d want 0 %0d", i, rif.alloc_e_, rif.alloc_rob_id, m_tail); end
            n_checks++; if (occ[rif.alloc_rob_id] !== 1'b0) begin n_fail++; $display("FAIL stream_reuse id %0d issued while occupied", rif.alloc_rob_id); end
            occ[rif.alloc_rob_id] = 1'b1;
            exp_com_q.push_back(m_tail);
            m_tail = (m_tail + 1) % DEPTH;
            exp_c = (i >= NB) ? 1'b0 : 1'b1;
            n_checks++; if (rif.commit_e_ !== exp_c) begin n_fail++; $display("FAIL stream_commit i%0d got %b want %b", i, rif.commit_e_, exp_c); end
            if (!rif.commit_e_) begin
                n_checks++;
                if (exp_com_q.size() == 0 || rif.com_rob_id !== 4'(exp_com_q[0])) begin n_fail++; $display("FAIL stream_com_id got %0d queued=%0d", rif.com_rob_id, exp_com_q.size()); end
                if (exp_com_q.size() != 0) void'(exp_com_q.pop_front());
                occ[rif.com_rob_id] = 1'b0;
            end
            exp_cnt = (i == 0) ? 4 : 4 + NB;
            n_checks++; if (rif.count !== 5'(exp_cnt)) begin n_fail++; $display("FAIL stream_count i%0d got %0d want %0d", i, rif.count, exp_cnt); end
            wb_ptr = (wb_ptr + 1) % DEPTH;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_wb_latency();
        logic exp_c;
        apply_reset();
        rif.alloc_req_ = 1'b0;
        #3;
        n_checks++; if (rif.alloc_e_ !== 1'b0 || rif.alloc_rob_id !== 4'd0) begin n_fail++; $display("FAIL lat_grant got e=%b id=%0d want 0 0", rif.alloc_e_, rif.alloc_rob_id); end
        exp_com_q.push_back(0);
        tick();
        rif.alloc_req_ = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rif.wb_e_     = (c == 0) ? 1'b0 : 1'b1;
            rif.wb_rob_id = 4'd0;
            #3;
            exp_c = (c == NB) ? 1'b0 : 1'b1;
            n_checks++; if (rif.commit_e_ !== exp_c) begin n_fail++; $display("FAIL lat_commit c%0d got %b want %b", c, rif.commit_e_, exp_c); end
            if (!rif.commit_e_) begin
                n_checks++;
                if (exp_com_q.size() == 0 || rif.com_rob_id !== 4'(exp_com_q[0])) begin n_fail++; $display("FAIL lat_com_id got %0d queued=%0d", rif.com_rob_id, exp_com_q.size()); end
                if (exp_com_q.size() != 0) void'(exp_com_q.pop_front());
            end
            tick();
        end
        #3;
        n_checks++; if (rif.count !== 5'd0 || rif.empty !== 1'b1) begin n_fail++; $display("FAIL lat_drained got count=%0d empty=%b want 0 1", rif.count, rif.empty); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timed out");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_fill();
        test_full_wrap();
        test_out_of_order();
        test_flush();
        test_streaming();
        test_wb_latency();
        n_checks++; if (exp_com_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d entries want 0", exp_com_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
